// File: rtl/fetch_mem_arbiter.sv
// Arbiter sharing one single-ported memory between the fetch stage (read-only)
// and the memory stage (read/write), with flush cancellation and a watchdog.
module fetch_mem_arbiter #(
    parameter int N       = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ifReq,
    input  logic [N-1:0] ifAddr,
    input  logic         ifFlush,
    output logic [N-1:0] ifRdata,
    output logic         ifDone,
    output logic         ifStall,
    input  logic         memReq,
    input  logic         memWe,
    input  logic [N-1:0] memAddr,
    input  logic [N-1:0] memWdata,
    output logic [N-1:0] memRdata,
    output logic         memDone,
    output logic         memStall,
    output logic         ramCs,
    output logic         ramWe,
    output logic [N-1:0] ramAddr,
    output logic [N-1:0] ramWdata,
    input  logic [N-1:0] ramRdata,
    input  logic         ramReady,
    output logic         timeoutErr
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE_IF  = 2'd1,
        SERVE_MEM = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic             r_lastMem;
    logic             r_cancel;
    logic [CNT_W-1:0] r_wdCnt;
    logic             r_ramWe;
    logic [N-1:0]     r_ramAddr;
    logic [N-1:0]     r_ramWdata;
    logic [N-1:0]     r_ifRdata;
    logic [N-1:0]     r_memRdata;
    logic             r_ifDone;
    logic             r_memDone;
    logic             r_timeoutErr;

    logic w_effIf;
    logic w_effMem;
    logic w_grantMem;
    logic w_grantIf;
    logic w_serving;
    logic w_timeout;
    logic w_ifComplete;
    logic w_memComplete;
    logic w_stayServing;

    // The done terms keep a requester still holding its request in the done cycle from being re-granted.
    assign w_effIf  = ifReq & ~ifFlush & ~r_ifDone;
    assign w_effMem = memReq & ~r_memDone;

    // On a tie the requester that did not win last time gets the memory.
    assign w_grantMem = w_effMem & (~w_effIf | ~r_lastMem);
    assign w_grantIf  = w_effIf & ~w_grantMem;

    assign w_serving     = (r_state != IDLE);
    assign w_timeout     = w_serving && !ramReady && (r_wdCnt == CNT_W'(TIMEOUT - 1));
    assign w_ifComplete  = (r_state == SERVE_IF) && ramReady && !r_cancel && !ifFlush;
    assign w_memComplete = (r_state == SERVE_MEM) && ramReady;
    assign w_stayServing = w_serving && (w_nextState != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_grantMem) begin
                    w_nextState = SERVE_MEM;
                end else if (w_grantIf) begin
                    w_nextState = SERVE_IF;
                end
            end
            SERVE_IF, SERVE_MEM: begin
                if (ramReady || w_timeout) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        ramCs = 1'b0;
        ramWe = 1'b0;
        if (w_serving) begin
            ramCs = 1'b1;
            ramWe = r_ramWe;
        end
    end

    // Request parameters are latched at grant so the RAM side stays stable while serving.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lastMem  <= 1'b0;
            r_ramWe    <= 1'b0;
            r_ramAddr  <= '0;
            r_ramWdata <= '0;
        end else if ((r_state == IDLE) && (w_grantMem || w_grantIf)) begin
            r_lastMem  <= w_grantMem;
            r_ramWe    <= w_grantMem & memWe;
            r_ramAddr  <= w_grantMem ? memAddr : ifAddr;
            r_ramWdata <= w_grantMem ? memWdata : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ifDone   <= 1'b0;
            r_memDone  <= 1'b0;
            r_ifRdata  <= '0;
            r_memRdata <= '0;
        end else begin
            r_ifDone  <= w_ifComplete;
            r_memDone <= w_memComplete;
            if (w_ifComplete) begin
                r_ifRdata <= ramRdata;
            end
            if (w_memComplete && !r_ramWe) begin
                r_memRdata <= ramRdata;
            end
        end
    end

    // A cancelled fetch still runs to completion on the RAM but delivers nothing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cancel <= 1'b0;
        end else if ((r_state == SERVE_IF) && (w_nextState == SERVE_IF)) begin
            r_cancel <= r_cancel | ifFlush;
        end else begin
            r_cancel <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdCnt      <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            if (w_stayServing) begin
                r_wdCnt <= r_wdCnt + 1'b1;
            end else begin
                r_wdCnt <= '0;
            end
            if (w_timeout) begin
                r_timeoutErr <= 1'b1;
            end
        end
    end

    assign ifStall    = ifReq & ~r_ifDone;
    assign memStall   = memReq & ~r_memDone;
    assign ifRdata    = r_ifRdata;
    assign ifDone     = r_ifDone;
    assign memRdata   = r_memRdata;
    assign memDone    = r_memDone;
    assign ramAddr    = r_ramAddr;
    assign ramWdata   = r_ramWdata;
    assign timeoutErr = r_timeoutErr;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Directed bench for fetch_mem_arbiter: arbitration order, flush, watchdog and reset.
module tb_fetch_mem_arbiter;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         ifReq, ifFlush, memReq, memWe, ramReady;
    logic [N-1:0] ifAddr, memAddr, memWdata, ramRdata;
    logic [N-1:0] ifRdata, memRdata, ramAddr, ramWdata;
    logic         ifDone, ifStall, memDone, memStall, ramCs, ramWe, timeoutErr;

    int errorCount = 0;
    int checkCount = 0;

    fetch_mem_arbiter #(.N(N), .TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifFlush(ifFlush),
        .ifRdata(ifRdata), .ifDone(ifDone), .ifStall(ifStall),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .memDone(memDone), .memStall(memStall),
        .ramCs(ramCs), .ramWe(ramWe), .ramAddr(ramAddr), .ramWdata(ramWdata),
        .ramRdata(ramRdata), .ramReady(ramReady), .timeoutErr(timeoutErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        applyStimulus();
        applyStimulus();
        rst = 1'b1;
    endtask

    initial begin
        ifReq = 0; ifFlush = 0; ifAddr = '0;
        memReq = 0; memWe = 0; memAddr = '0; memWdata = '0;
        ramRdata = '0; ramReady = 1'b1;
        doReset();

        checkOutput("rst_ramCs", ramCs, 0);
        checkOutput("rst_ramWe", ramWe, 0);
        checkOutput("rst_ramAddr", ramAddr, 0);
        checkOutput("rst_ramWdata", ramWdata, 0);
        checkOutput("rst_ifRdata", ifRdata, 0);
        checkOutput("rst_memRdata", memRdata, 0);
        checkOutput("rst_dones", {ifDone, memDone}, 0);
        checkOutput("rst_stalls", {ifStall, memStall}, 0);
        checkOutput("rst_timeoutErr", timeoutErr, 0);

        // Single fetch at minimum latency.
        ifReq = 1; ifAddr = 32'h10; ramRdata = 32'hE3A01005;
        applyStimulus();
        checkOutput("f1_ramCs", ramCs, 1);
        checkOutput("f1_ramAddr", ramAddr, 32'h10);
        checkOutput("f1_ramWe", ramWe, 0);
        checkOutput("f1_ifStall", ifStall, 1);
        applyStimulus();
        checkOutput("f2_ifDone", ifDone, 1);
        checkOutput("f2_ifRdata", ifRdata, 32'hE3A01005);
        checkOutput("f2_ifStall", ifStall, 0);
        checkOutput("f2_ramCs", ramCs, 0);
        ifReq = 0;
        applyStimulus();
        checkOutput("f3_ifDone", ifDone, 0);

        // Simultaneous write and fetch straight after reset: MEM wins the tie.
        doReset();
        memReq = 1; memWe = 1; memAddr = 32'h40; memWdata = 32'hDEADBEEF;
        ifReq = 1; ifAddr = 32'h20; ramRdata = 32'h11111111; ramReady = 1;
        applyStimulus();
        checkOutput("t2_ramCs", ramCs, 1);
        checkOutput("t2_ramWe", ramWe, 1);
        checkOutput("t2_ramAddr", ramAddr, 32'h40);
        checkOutput("t2_ramWdata", ramWdata, 32'hDEADBEEF);
        checkOutput("t2_memStall", memStall, 1);
        checkOutput("t2_ifStall1", ifStall, 1);
        applyStimulus();
        checkOutput("t2_memDone", memDone, 1);
        checkOutput("t2_memRdata", memRdata, 0);
        checkOutput("t2_memStall_done", memStall, 0);
        checkOutput("t2_idle_ramCs", ramCs, 0);
        checkOutput("t2_ifStall2", ifStall, 1);
        memReq = 0; memWe = 0;
        applyStimulus();
        checkOutput("t2_if_ramCs", ramCs, 1);
        checkOutput("t2_if_ramAddr", ramAddr, 32'h20);
        checkOutput("t2_if_ramWe", ramWe, 0);
        checkOutput("t2_if_ramWdata", ramWdata, 0);
        checkOutput("t2_memDone_off", memDone, 0);
        checkOutput("t2_ifStall3", ifStall, 1);
        applyStimulus();
        checkOutput("t2_ifDone", ifDone, 1);
        checkOutput("t2_ifRdata", ifRdata, 32'h11111111);
        checkOutput("t2_ifStall4", ifStall, 0);
        ifReq = 0;

        // Both requesters continuously active, RAM answers in the third serve cycle.
        ramReady = 0;
        memReq = 1; memWe = 0; memAddr = 32'h80;
        ifReq = 1; ifAddr = 32'h30;
        for (int t = 0; t < 4; t++) begin
            logic isMem;
            isMem = (t % 2 == 0);
            applyStimulus();
            checkOutput($sformatf("rr%0d_ramCs", t), ramCs, 1);
            checkOutput($sformatf("rr%0d_ramAddr", t), ramAddr, isMem ? 32'h80 : 32'h30);
            checkOutput($sformatf("rr%0d_donesLow", t), {ifDone, memDone}, 0);
            applyStimulus();
            applyStimulus();
            ramReady = 1; ramRdata = 32'hA0000000 + t;
            applyStimulus();
            ramReady = 0;
            checkOutput($sformatf("rr%0d_memDone", t), memDone, isMem);
            checkOutput($sformatf("rr%0d_ifDone", t), ifDone, !isMem);
            checkOutput($sformatf("rr%0d_rdata", t), isMem ? memRdata : ifRdata, 32'hA0000000 + t);
            checkOutput($sformatf("rr%0d_idle", t), ramCs, 0);
        end
        memReq = 0; ifReq = 0;
        applyStimulus();
        checkOutput("rr_end_dones", {ifDone, memDone}, 0);
        checkOutput("rr_end_ramCs", ramCs, 0);

        // Fetch flushed in its second serve cycle; the redirected fetch completes.
        ifReq = 1; ifAddr = 32'h08; ramReady = 0;
        applyStimulus();
        checkOutput("fl_s1_ramAddr", ramAddr, 32'h08);
        applyStimulus();
        ifFlush = 1; ifAddr = 32'h100;
        applyStimulus();
        ifFlush = 0;
        checkOutput("fl_s3_ramCs", ramCs, 1);
        applyStimulus();
        ramReady = 1; ramRdata = 32'hBAD0BAD0;
        applyStimulus();
        ramReady = 0;
        checkOutput("fl_noDone", ifDone, 0);
        checkOutput("fl_rdataKept", ifRdata, 32'hA0000003);
        checkOutput("fl_idle", ramCs, 0);
        applyStimulus();
        checkOutput("fl_new_ramCs", ramCs, 1);
        checkOutput("fl_new_ramAddr", ramAddr, 32'h100);
        ramReady = 1; ramRdata = 32'h12345678;
        applyStimulus();
        checkOutput("fl_new_ifDone", ifDone, 1);
        checkOutput("fl_new_ifRdata", ifRdata, 32'h12345678);
        ifReq = 0; ramReady = 0;
        applyStimulus();

        // Watchdog: eight serve cycles without ramReady, then a retry.
        memReq = 1; memWe = 0; memAddr = 32'h44;
        for (int c = 1; c <= 8; c++) begin
            applyStimulus();
            checkOutput($sformatf("wd_serve%0d_ramCs", c), ramCs, 1);
            checkOutput($sformatf("wd_serve%0d_err", c), timeoutErr, 0);
        end
        applyStimulus();
        checkOutput("wd_idle_ramCs", ramCs, 0);
        checkOutput("wd_err_set", timeoutErr, 1);
        checkOutput("wd_noDone", memDone, 0);
        checkOutput("wd_stall", memStall, 1);
        ramReady = 1; ramRdata = 32'h55AA55AA;
        applyStimulus();
        checkOutput("wd_retry_ramCs", ramCs, 1);
        checkOutput("wd_retry_ramAddr", ramAddr, 32'h44);
        applyStimulus();
        checkOutput("wd_retry_memDone", memDone, 1);
        checkOutput("wd_retry_memRdata", memRdata, 32'h55AA55AA);
        checkOutput("wd_err_sticky", timeoutErr, 1);
        memReq = 0; ramReady = 0;
        applyStimulus();

        // Asynchronous reset in the second serve cycle of a MEM read.
        memReq = 1; memWe = 0; memAddr = 32'h60;
        applyStimulus();
        applyStimulus();
        checkOutput("ar_s2_ramCs", ramCs, 1);
        rst = 0;
        #1;
        checkOutput("ar_ramCs", ramCs, 0);
        checkOutput("ar_memDone", memDone, 0);
        checkOutput("ar_ramAddr", ramAddr, 0);
        checkOutput("ar_timeoutErr", timeoutErr, 0);
        checkOutput("ar_memRdata", memRdata, 0);
        applyStimulus();
        checkOutput("ar_held_memDone", memDone, 0);
        rst = 1;
        #1;
        checkOutput("ar_rel_ramCs", ramCs, 0);
        ramReady = 1; ramRdata = 32'h600D600D;
        applyStimulus();
        checkOutput("ar_new_ramCs", ramCs, 1);
        checkOutput("ar_new_ramAddr", ramAddr, 32'h60);
        applyStimulus();
        checkOutput("ar_new_memDone", memDone, 1);
        checkOutput("ar_new_memRdata", memRdata, 32'h600D600D);
        memReq = 0; ramReady = 0;
        applyStimulus();
        checkOutput("ar_new_pulse", memDone, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fetch_mem_arbiter.md
Name: fetch_mem_arbiter

Overview:
- Shares one single-ported instruction/data memory between the fetch stage (read-only) and the memory stage (read/write).
- Serialises requests, drives the RAM-side handshake, and returns read data with one-cycle done pulses.
- Supplies stall signals that feed the pipeline freeze logic.
- Handles fetch cancellation on taken branches, and includes a watchdog for a memory that never responds.

Parameters:
- N, 32, address and data width.
- TIMEOUT, 255, maximum cycles in a serve state before the watchdog aborts; must be ≥ 2.
- CNT_W, 8, watchdog counter width; requires 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- ifReq  in  1  fetch read request; held until ifDone or flushed.
- ifAddr  in  N  fetch address (PC).
- ifFlush  in  1  branch taken; cancel pending or in-flight fetch.
- ifRdata  out  N  fetched instruction; valid while ifDone=1.
- ifDone  out  1  one-cycle pulse, fetch complete.
- ifStall  out  1  fetch must freeze.
- memReq  in  1  data request; held until memDone.
- memWe  in  1  1 = write, 0 = read.
- memAddr  in  N  data address.
- memWdata  in  N  write data.
- memRdata  out  N  read data; valid while memDone=1.
- memDone  out  1  one-cycle pulse, data access complete.
- memStall  out  1  memory stage must stall.
- ramCs  out  1  RAM chip select.
- ramWe  out  1  RAM write enable.
- ramAddr  out  N  RAM address.
- ramWdata  out  N  RAM write data.
- ramRdata  in  N  RAM read data; valid when ramReady=1.
- ramReady  in  1  RAM access complete this cycle.
- timeoutErr  out  1  sticky watchdog error flag.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state=IDLE; lastGrant=IF.
  - all outputs 0, including ifRdata, memRdata and the ram* outputs.
  - watchdog counter=0; timeoutErr=0.
- A reset mid-transaction abandons the transaction. No done pulse is produced.
- States are IDLE, SERVE_IF and SERVE_MEM.
- Request masking:
  - effIf = ifReq & ~ifFlush & ~ifDone.
  - effMem = memReq & ~memDone.
  - The done term stops a requester that is still holding its request in the done cycle from being re-granted.
- IDLE transitions:
  - effMem only → SERVE_MEM.
  - effIf only → SERVE_IF.
  - Both asserted → grant the requester other than lastGrant (round-robin). After reset, MEM wins the first tie.
  - Neither asserted → stay in IDLE.
- On grant, latch the following into registers and set lastGrant to the winner:
  - ramAddr, and ramWe (MEM: memWe; IF: 0).
  - ramWdata (MEM: memWdata; IF: 0).
- In SERVE_*, ramCs=1 and ramAddr, ramWe and ramWdata are held stable. In IDLE, ramCs=0 and ramWe=0.
- Transaction completion: ramReady=1 in SERVE_* →
  - capture ramRdata into ifRdata or memRdata;
  - next cycle, pulse ifDone or memDone for exactly 1 cycle;
  - return to IDLE.
- Writes also pulse memDone; memRdata is then unchanged.
- Minimum latency: request sampled at edge k → ramCs high in cycle k+1 → with ramReady in k+1, done high in k+2. There is always ≥ 1 IDLE cycle (the done cycle) between transactions.
- Fetch flush:
  - ifFlush=1 during SERVE_IF sets a cancel flag. The RAM access still completes, since reads are harmless, but ifDone and the ifRdata update are suppressed.
  - The cancel flag clears on leaving SERVE_IF.
  - ifFlush coinciding with ramReady also suppresses completion.
  - ifFlush in IDLE blocks the IF grant for that cycle only.
- ifFlush never affects MEM transactions.
- Stall outputs (combinational):
  - ifStall = ifReq & ~ifDone.
  - memStall = memReq & ~memDone.
- Watchdog:
  - the counter increments each cycle in SERVE_* and clears in IDLE.
  - If it reaches TIMEOUT without ramReady, go to IDLE, set timeoutErr=1 until reset, and give no done pulse.
  - The requester's request remains pending and is retried by normal arbitration.
- ramReady in IDLE is ignored.

Test Plan:
- Reset with ramReady tied to 1 → all outputs 0.
  - Then ifReq=1, ifAddr=0x10, ramRdata=0xE3A01005 → ramCs=1 and ramAddr=0x10 at cycle 1; ifDone=1 and ifRdata=0xE3A01005 at cycle 2; ifStall=0 at cycle 2.
- memReq=1 and memWe=1 (memAddr=0x40, memWdata=0xDEADBEEF) together with ifReq=1 (ifAddr=0x20), from reset → MEM granted first:
  - ramWe=1, ramAddr=0x40, ramWdata=0xDEADBEEF, memDone pulse;
  - then IF served with ramAddr=0x20;
  - ifStall=1 throughout until ifDone.
- Both requesters continuously requesting, ramReady after 3 cycles → grant order alternates MEM, IF, MEM, IF; each done pulse is exactly 1 cycle wide.
- ifReq=1 at ifAddr=0x08, ramReady delayed 4 cycles, ifFlush pulsed in serve cycle 2 → no ifDone and ifRdata unchanged.
  - Then the new ifAddr=0x100 is granted and completes normally.
- ramReady held at 0 with TIMEOUT=8 → return to IDLE after 8 serve cycles and timeoutErr=1.
  - With ramReady restored, the request is retried and completes; timeoutErr stays 1 until rst=0.
- rst=0 asserted in serve cycle 2 of a MEM read → state, ramCs and memDone are 0 immediately; after release, a new request is served normally.
